seq_ram_player: RTL
===================

Name: seq_ram_player

Overview:
- Parametrised record/playback sequencer around an internal single-port-style RAM of DEPTH words × DATA_W bits.
- Record mode: user strobes write successive samples.
- Play mode: stored samples are stepped out at a fixed tick rate to drive LEDs or downstream logic.
- Sits between the board-level debounce block and the LED/pmod outputs; generalises the fixed 4-address, 2-bit sequencer.

Parameters:
- DATA_W, 2, width of each stored sample and of data_in/data_out.
- DEPTH, 16, number of RAM words; must be a power of two, ≥ 2.
- ADDR_W, 4, address width; must equal log2(DEPTH).
- STEP_DIV, 12000000, clk cycles per playback step; ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rec_mode  in  1  level; high selects record mode.
- play_mode  in  1  level; high selects play mode.
- clear  in  1  single-cycle strobe; erase RAM and length.
- wr_strobe  in  1  single-cycle strobe from upstream debouncer; record one sample.
- data_in  in  DATA_W  sample captured on wr_strobe.
- data_out  out  DATA_W  registered playback sample.
- addr  out  ADDR_W  current record/play address.
- length  out  ADDR_W+1  number of valid recorded samples, 0..DEPTH.
- full  out  1  high when length == DEPTH.
- busy  out  1  high while CLEAR is walking RAM.
- done  out  1  one-cycle pulse at end of a non-looping playback pass.

Behaviour:
- Reset: state=IDLE, addr=0, length=0, data_out=0, full=0, busy=0, done=0, step counter=0. RAM contents are not reset.
- States are IDLE, RECORD, PLAY and CLEAR. Decisions are evaluated each cycle with priority clear > rec_mode > play_mode.
- IDLE:
  - clear -> CLEAR.
  - rec_mode -> RECORD, with addr=length (append).
  - play_mode and length>0 -> PLAY, with addr=0 and step counter=0.
  - play_mode with length==0 stays IDLE.
- RECORD:
  - wr_strobe with full=0 -> RAM[addr]<=data_in, addr++, length++.
  - wr_strobe with full=1 is ignored; no write, no counter change.
  - rec_mode low -> IDLE next cycle.
  - clear -> CLEAR, aborting record.
- PLAY:
  - Read is issued on entry and on each step tick.
  - RAM read has one-cycle latency: data_out updates the cycle after the read is issued.
  - Step tick occurs when the step counter reaches STEP_DIV-1; the counter then returns to 0 and addr advances.
  - When addr==length-1 at a tick, the end-of-pass rule applies (see Optional Feature).
  - play_mode low -> IDLE; data_out holds its last value.
  - rec_mode high -> RECORD.
  - clear -> CLEAR.
- CLEAR:
  - busy=1. Writes 0 to RAM[0..DEPTH-1], one address per cycle (DEPTH cycles).
  - Then length=0, addr=0, data_out=0, busy=0 -> IDLE.
  - All mode inputs, wr_strobe and further clear strobes are ignored while busy.
- Simultaneous wr_strobe and mode change: the strobe is honoured only if the current state is RECORD in that cycle.
- Arithmetic:
  - length counts to DEPTH inclusive, hence ADDR_W+1 bits.
  - addr wraps modulo DEPTH.
  - full is combinational from length.
- Reset mid-CLEAR or mid-PLAY returns immediately to reset values; partially cleared RAM is acceptable.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: at the end of a pass, addr wraps to 0 and playback continues indefinitely; done is never asserted.
- Undefined: at the end of a pass, done pulses for one cycle, state -> IDLE, addr=0, and data_out holds the last sample. Restart requires play_mode to go low then high again.

Test Plan (STEP_DIV=4, DEPTH=16, DATA_W=2):
- Reset then idle 10 cycles -> data_out=0, addr=0, length=0, full=0, busy=0, done=0.
- Record 3, 1, 2 via wr_strobe in RECORD -> length=3, addr=3. Then PLAY -> data_out sequence 3, 1, 2, each held 4 cycles, first valid 1 cycle after PLAY entry.
- Record 16 samples then 1 extra strobe -> full=1, length=16, RAM[0] unchanged, addr=0 (wrapped).
- clear strobe during PLAY -> busy high exactly 16 cycles, then length=0, data_out=0. A subsequent PLAY request stays in IDLE.
- Without SEQ_LOOP_EN, play length=2 -> done pulses once, 1 cycle, after the 2nd step's tick; state IDLE. With SEQ_LOOP_EN -> output repeats 0th,1st,0th,... and done stays 0.
- Assert reset mid-RECORD after 5 writes -> all outputs return to reset values next cycle; length=0.

Source files
------------

// File: rtl/seq_ram_player.sv
// Record/playback sequencer around a DEPTH x DATA_W RAM, stepped out at STEP_DIV clocks per sample.
// Optional macro SEQ_LOOP_EN: playback wraps forever instead of ending with a done pulse.
module seq_ram_player #(
   parameter int unsigned DATA_W   = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned STEP_DIV = 12000000
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rec_mode_i,
   input  logic              play_mode_i,
   input  logic              clear_i,
   input  logic              wr_strobe_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W:0]   length_o,
   output logic              full_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned CNT_W = $clog2(STEP_DIV);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RECORD = 2'd1;
   localparam logic [1:0] S_PLAY   = 2'd2;
   localparam logic [1:0] S_CLEAR  = 2'd3;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [ADDR_W:0]   len_q,   len_d;
   logic [DATA_W-1:0] dout_q,  dout_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              lock_q,  lock_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              full_c;
   logic              last_addr_c;
   logic              tick_c;

   assign full_c      = (len_q == (ADDR_W+1)'(DEPTH));
   assign last_addr_c = ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));
   assign tick_c      = (cnt_q == CNT_W'(STEP_DIV - 1));

   // Next-state logic; priority clear > rec_mode > play_mode
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      dout_d    = dout_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      lock_d    = lock_q & play_mode_i;
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = data_in_i;

      case (state_q)
         S_IDLE: begin
            if (clear_i) begin
               state_d = S_CLEAR;
               addr_d  = '0;
               busy_d  = 1'b1;
            end else if (rec_mode_i) begin
               state_d = S_RECORD;
               addr_d  = ADDR_W'(len_q);
            end else if (play_mode_i && (len_q != '0) && !lock_q) begin
               state_d = S_PLAY;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         S_RECORD: begin
            if (clear_i) begin
               state_d = S_CLEAR;
               addr_d  = '0;
               busy_d  = 1'b1;
            end else begin
               if (wr_strobe_i && !full_c) begin
                  mem_we = 1'b1;
                  addr_d = addr_q + ADDR_W'(1);
                  len_d  = len_q + (ADDR_W+1)'(1);
               end
               if (!rec_mode_i) state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (clear_i) begin
               state_d = S_CLEAR;
               addr_d  = '0;
               busy_d  = 1'b1;
            end else if (rec_mode_i) begin
               state_d = S_RECORD;
               addr_d  = ADDR_W'(len_q);
            end else if (!play_mode_i) begin
               state_d = S_IDLE;
            end else begin
               // A counter value of zero marks a freshly issued read
               if (cnt_q == '0) dout_d = mem[addr_q];
               if (tick_c) begin
                  cnt_d = '0;
                  if (last_addr_c) begin
`ifdef SEQ_LOOP_EN
                     addr_d = '0;
`else
                     addr_d  = '0;
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     lock_d  = 1'b1;
`endif
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            mem_we    = 1'b1;
            mem_wdata = '0;
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = S_IDLE;
               addr_d  = '0;
               len_d   = '0;
               dout_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lock_q  <= lock_d;
      end
   end

   // Sample RAM, intentionally not reset
   always_ff @(posedge clk_i) begin
      if (mem_we && !reset_i) mem[mem_waddr] <= mem_wdata;
   end

   assign data_out_o = dout_q;
   assign addr_o     = addr_q;
   assign length_o   = len_q;
   assign full_o     = full_c;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule
